// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind valid/ready request and
// response channels. Each access waits a programmable number of cycles and
// then completes. Byte, halfword and word sizes are supported, with sign or
// zero extension on loads. Misaligned, out-of-range and illegal-funct3
// requests fault without touching the RAM.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned AddrW = DEPTH_LOG2 + 2;
    localparam int unsigned CntW  = 4;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [AddrW-1:0]     addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [31:0]          mem [Depth];

    logic                 hs;
    logic                 req_err;
    logic                 funct3_bad;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 access;
    logic                 mem_we;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]           lane;
    logic [31:0]          word;
    logic [31:0]          shifted;
    logic [31:0]          load_data;
    logic [31:0]          store_word;

    assign hs = req_valid_i & req_ready_o;

    // Fault classification of the incoming request, evaluated at handshake.
    always_comb begin
        funct3_bad = 1'b0;
        if (req_we_i) begin
            funct3_bad = !(req_funct3_i inside {3'b000, 3'b001, 3'b010});
        end else begin
            funct3_bad = !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misaligned = 1'b0;
        case (req_funct3_i[1:0])
            2'b01:   misaligned = req_addr_i[0];
            2'b10:   misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = |req_addr_i[31:AddrW];
        req_err      = funct3_bad | misaligned | out_of_range;
    end

    // Load extraction and store merge on the registered request.
    always_comb begin
        idx        = addr_q[AddrW-1:2];
        lane       = addr_q[1:0];
        word       = mem[idx];
        shifted    = word >> {lane, 3'b000};
        load_data  = word;
        store_word = word;
        unique case (funct3_q[1:0])
            2'b00: begin
                load_data = funct3_q[2] ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
                unique case (lane)
                    2'd0: store_word[7:0]   = wdata_q[7:0];
                    2'd1: store_word[15:8]  = wdata_q[7:0];
                    2'd2: store_word[23:16] = wdata_q[7:0];
                    2'd3: store_word[31:24] = wdata_q[7:0];
                    default: store_word = word;
                endcase
            end
            2'b01: begin
                load_data = funct3_q[2] ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
                if (lane[1]) begin
                    store_word[31:16] = wdata_q[15:0];
                end else begin
                    store_word[15:0] = wdata_q[15:0];
                end
            end
            default: begin
                load_data  = word;
                store_word = wdata_q;
            end
        endcase
    end

    assign access = (state_q == StWait) && (cnt_q == '0);
    // A reset landing on the access cycle must suppress the store.
    assign mem_we = access && we_q && rst_n;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    state_d = req_err ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

    // Wait counter and response next-state.
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (hs) begin
            err_d   = req_err;
            rdata_d = '0;
            cnt_d   = req_err ? '0 : CntW'(LATENCY - 1);
        end else if (state_q == StWait) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                rdata_d = we_q ? '0 : load_data;
                err_d   = 1'b0;
            end
        end
    end

    // Request capture and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (hs) begin
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i[AddrW-1:0];
                wdata_q  <= req_wdata_i;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores, sized loads, faults,
// response backpressure and reset during a pending store.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .DEPTH_LOG2(8),
        .LATENCY   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_funct3_i(req_funct3),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction with the consumer always ready.
    // exp_lat counts clock edges after the accepting edge until rsp_valid.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw10");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw10");
        txn(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 2, "sb11");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, 2, "lw10b");
        txn(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, "lb13");
        txn(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, "lbu13");
        txn(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, "lh12");
        txn(1'b0, 3'b101, 32'h10, 32'h0, 32'h00005AEF, 1'b0, 2, "lhu10");

        // Faults respond on the cycle after accept and leave RAM untouched.
        txn(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0, "lw12_mis");
        txn(1'b1, 3'b010, 32'h0C, 32'h11223344, 32'h0, 1'b0, 2, "sw0c");
        txn(1'b1, 3'b001, 32'h0F, 32'h0000AAAA, 32'h0, 1'b1, 0, "sh0f_mis");
        txn(1'b0, 3'b010, 32'h0C, 32'h0, 32'h11223344, 1'b0, 2, "lw0c");
        txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 0, "lw400_oor");
        txn(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 0, "st_f3_100");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, 2, "lw10c");
        txn(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0, "ld_f3_011");
        txn(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0, 2, "sw14");

        // Backpressure: response held while a different request waits.
        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_busy", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_rdata", rsp_rdata, 32'hDEAD5AEF);
        req_valid = 1'b1;
        req_addr  = 32'h14;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_hold_rdata", rsp_rdata, 32'hDEAD5AEF);
            chk("bp_hold_err", {31'b0, rsp_err}, 32'd0);
            chk("bp_hold_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rsp_done", {31'b0, rsp_valid}, 32'd0);
        chk("bp_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_2nd_accept", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp_2nd_wait", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp_2nd_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_2nd_rdata", rsp_rdata, 32'hCAFEF00D);
        @(posedge clk);
        #1;

        // Reset on the access cycle of a pending store.
        txn(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 2, "sw20_clr");
        txn(1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 2, "lw14");
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rw_wait", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rw_ready", {31'b0, req_ready}, 32'd1);
        chk("rw_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rw_rdata", rsp_rdata, 32'd0);
        chk("rw_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 2, "lw20");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
